// File: rtl/id_pkg.sv
// Shared types and constants for the decode stage and its register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package id_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int CW_DEF   = 16;
    localparam int IMM_W    = 26;

    // Immediate field selector encoding, as presented by the decoder.
    typedef enum logic [1:0] {
        IMM12    = 2'b00,
        IMM_DT9  = 2'b01,
        IMM_CB19 = 2'b10,
        IMM_B26  = 2'b11
    } imm_sel_t;

    // The highest architectural register index is the hard-wired zero register.
    function automatic int XZR_IDX(input int nreg);
        return nreg - 1;
    endfunction

endpackage

// File: rtl/id_stage_fwd_regfile_wt.sv
// Register file: NREG x XLEN, two combinational read ports, one synchronous write port.
// Latency: reads are combinational; a write is visible on the read ports the cycle after it.
// Backpressure: none; XZR reads 0 and ignores writes. Same-cycle write-through is done by the parent.
// Ports: clk/reset, raddr_a/rdata_a, raddr_b/rdata_b, we/waddr/wdata.
module regfile_wt
    import id_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    localparam logic [AW-1:0] XZR = AW'(XZR_IDX(NREG));

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != XZR)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == XZR) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == XZR) ? '0 : mem[raddr_b];

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: regfile read, EX/MEM/WB operand forwarding, immediate sign-extension, ID/EX register.
// Latency: one cycle from ID to EX.
// Backpressure: id_stall holds PC and IF/ID on a load-use hazard (suppressed by flush); a bubble enters EX.
// Ports: id_* decoded instruction, fw_ex_*/fw_mem_*/wb_* forwarding sources (wb_* also writes the
// regfile), flush, id_stall, ex_* registered outputs to the EX stage.
module id_stage_fwd
    import id_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = CW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rn,
    input  logic [AW-1:0]    id_rm,
    input  logic [AW-1:0]    id_rd,
    input  logic             id_reg2loc,
    input  logic             id_uses_a,
    input  logic             id_uses_b,
    input  logic [IMM_W-1:0] id_imm,
    input  logic [1:0]       id_imm_sel,
    input  logic             id_mem_read,
    input  logic [CW-1:0]    id_ctrl,
    input  logic             fw_ex_we,
    input  logic [XLEN-1:0]  fw_ex_data,
    input  logic             fw_mem_we,
    input  logic [AW-1:0]    fw_mem_addr,
    input  logic [XLEN-1:0]  fw_mem_data,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    output logic             id_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_imm,
    output logic [AW-1:0]    ex_rd,
    output logic             ex_mem_read,
    output logic [CW-1:0]    ex_ctrl
);

    localparam logic [AW-1:0] XZR = AW'(XZR_IDX(NREG));

    logic [AW-1:0]   ab;
    logic [XLEN-1:0] rf_a, rf_b;
    logic [XLEN-1:0] opnd_a, opnd_b;
    logic [XLEN-1:0] imm_ext;
    logic            hz;

    assign ab = id_reg2loc ? id_rd : id_rm;

    regfile_wt #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (id_rn),
        .rdata_a (rf_a),
        .raddr_b (ab),
        .rdata_b (rf_b),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // Nearest older producer wins; XZR is never forwarded. The WB leg is the
    // write-through path for a regfile write landing on this same edge.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_hit_en,
        input logic [AW-1:0]   ex_addr,
        input logic [XLEN-1:0] ex_data,
        input logic            mem_en,
        input logic [AW-1:0]   mem_addr,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_en,
        input logic [AW-1:0]   wb_a,
        input logic [XLEN-1:0] wb_d
    );
        if (addr == XZR)                        return '0;
        else if (ex_hit_en && ex_addr == addr)  return ex_data;
        else if (mem_en && mem_addr == addr)    return mem_data;
        else if (wb_en && wb_a == addr)         return wb_d;
        else                                    return rf_val;
    endfunction

    always_comb begin
        opnd_a = fwd_sel(id_rn, rf_a, ex_valid & fw_ex_we, ex_rd, fw_ex_data,
                         fw_mem_we, fw_mem_addr, fw_mem_data, wb_we, wb_addr, wb_data);
        opnd_b = fwd_sel(ab, rf_b, ex_valid & fw_ex_we, ex_rd, fw_ex_data,
                         fw_mem_we, fw_mem_addr, fw_mem_data, wb_we, wb_addr, wb_data);
    end

    always_comb begin
        imm_ext = '0;
        case (imm_sel_t'(id_imm_sel))
            IMM12:    imm_ext = {{(XLEN-12){id_imm[11]}}, id_imm[11:0]};
            IMM_DT9:  imm_ext = {{(XLEN-9){id_imm[8]}},   id_imm[8:0]};
            IMM_CB19: imm_ext = {{(XLEN-19){id_imm[18]}}, id_imm[18:0]};
            IMM_B26:  imm_ext = {{(XLEN-26){id_imm[25]}}, id_imm[25:0]};
            default:  imm_ext = '0;
        endcase
    end

    // Load data only exists after MEM, so a matching load in EX must stall
    // regardless of fw_ex_we.
    assign hz = id_valid & ex_valid & ex_mem_read & (ex_rd != XZR) &
                ((id_uses_a & (id_rn == ex_rd)) | (id_uses_b & (ab == ex_rd)));

    // Flush discards the ID instruction, so there is nothing to hold.
    assign id_stall = hz & ~flush & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_mem_read <= 1'b0;
            ex_ctrl     <= '0;
        end else if (flush | hz | ~id_valid) begin
            // Bubble: only the fields that can cause side effects are cleared.
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
            ex_ctrl     <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_a        <= opnd_a;
            ex_b        <= opnd_b;
            ex_imm      <= imm_ext;
            ex_rd       <= id_rd;
            ex_mem_read <= id_mem_read;
            ex_ctrl     <= id_ctrl;
        end
    end

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
- Parametrised decode stage for the pipelined CPU: register file read, immediate sign-extension and ID/EX pipeline register in one block.
- Adds operand forwarding from EX, MEM and WB.
- Adds load-use hazard detection with an IF/ID stall, plus flush handling.
- Sits between the IF/ID register and the EX stage.

Parameters:
XLEN, 64, datapath width in bits
NREG, 32, number of architectural registers; index NREG-1 is the zero register (XZR)
AW, $clog2(NREG), register address width
CW, 16, width of opaque control bundle passed through to EX

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  instruction present in ID
id_rn  in  AW  A-read register
id_rm  in  AW  B-read register when id_reg2loc=0
id_rd  in  AW  destination; also B-read register when id_reg2loc=1
id_reg2loc  in  1  B-read select
id_uses_a  in  1  instruction consumes operand A
id_uses_b  in  1  instruction consumes operand B
id_imm  in  26  raw immediate, right-aligned
id_imm_sel  in  2  00 imm12, 01 DT9, 10 CB19, 11 B26
id_mem_read  in  1  instruction is a load
id_ctrl  in  CW  control bits for later stages
fw_ex_we  in  1  EX result will be written
fw_ex_data  in  XLEN  combinational EX result (destination is ex_rd)
fw_mem_we  in  1  MEM-stage write enable
fw_mem_addr  in  AW  MEM-stage destination
fw_mem_data  in  XLEN  MEM-stage result
wb_we  in  1  WB write enable
wb_addr  in  AW  WB destination
wb_data  in  XLEN  WB data
flush  in  1  discard instruction in ID
id_stall  out  1  hold PC and IF/ID
ex_valid  out  1  ID/EX valid
ex_a  out  XLEN  registered operand A
ex_b  out  XLEN  registered operand B
ex_imm  out  XLEN  registered sign-extended immediate
ex_rd  out  AW  registered destination
ex_mem_read  out  1  registered load flag
ex_ctrl  out  CW  registered control

Behaviour:
- Reset (posedge clk with reset=1):
  - all ex_* outputs go to 0 and all registers clear to 0.
  - id_stall is 0 while reset is high.
- Operand B address: ab = id_reg2loc ? id_rd : id_rm.
- Register file write: writes on the posedge when wb_we=1 and wb_addr!=NREG-1; writes to XZR are ignored.
- Operand select, per operand (A uses id_rn, B uses ab), in priority order:
  - address == NREG-1 → 0, never forwarded;
  - ex_valid & fw_ex_we & ex_rd==addr → fw_ex_data;
  - fw_mem_we & fw_mem_addr==addr → fw_mem_data;
  - wb_we & wb_addr==addr → wb_data (write-through in the same cycle);
  - otherwise the regfile value.
- Immediate:
  - the field selected by id_imm_sel (id_imm[11:0], [8:0], [18:0] or [25:0]) is sign-extended to XLEN.
  - shifting is done downstream.
- Load-use hazard:
  - condition: hz = id_valid & ex_valid & ex_mem_read & ex_rd!=NREG-1 & ((id_uses_a & id_rn==ex_rd) | (id_uses_b & ab==ex_rd)).
  - id_stall = hz & ~flush, combinational.
- ID/EX update each posedge:
  - reset → zeros.
  - else if flush | hz | ~id_valid → bubble: ex_valid=0, ex_mem_read=0, ex_ctrl=0. Other ex_* fields are don't-care and hold their previous value.
  - else capture the selected operands, immediate, id_rd, id_mem_read and id_ctrl; ex_valid=1.
- Latency: one cycle from ID to EX. A stalled instruction issues on the first cycle after hz clears.
- Flush and hazard in the same cycle: flush wins; a bubble is inserted and id_stall=0.
- Two instructions in flight to the same register: the nearest older one wins (EX > MEM > WB).
- Load in EX with a matching register: the stall occurs even if fw_ex_we=1, because load data is not ready in EX.

Decomposition:
- Shared package id_pkg holds:
  - imm_sel_t enum (IMM12, IMM_DT9, IMM_CB19, IMM_B26);
  - XZR_IDX function of NREG;
  - default widths.
- One sub-module: regfile_wt.
  - Parametrised NREG×XLEN.
  - Two combinational read ports, one synchronous write port.
  - XZR reads 0; write-through bypass lives in the parent forwarding mux.

Test Plan:
- Reset, then WB writes X5=0x1234 with id_rn=5 in the same cycle → ex_a=0x1234 next cycle, ex_valid=1.
- X3 in regfile=7, MEM writes X3=9 and EX result 11 targets ex_rd=3, id_rn=3 → ex_a=11. Drop EX forward → ex_a=9.
- id_imm_sel=01 with id_imm[8:0]=0x1FF → ex_imm=0xFFFF_FFFF_FFFF_FFFF. id_imm_sel=00 with 0x7FF → 0x7FF.
- Load in EX with ex_rd=4, ID instruction reads X4 → id_stall=1 for one cycle and ex_valid=0 (bubble). Next cycle, with fw_mem_data=0xAB → ex_a=0xAB, id_stall=0.
- Same load-use hazard plus flush=1 → id_stall=0, ex_valid=0.
- id_rn=31 with wb_we=1 writing X31=5 and EX forwarding to ex_rd=31 → ex_a=0. A later read of X31 is 0.
